// File: rtl/axil_pkg.sv
// Shared types and response codes for the AXI-lite memory bridge.
package axil_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    B_RSP   = 3'd2,
    RD_REQ  = 3'd3,
    RD_WAIT = 3'd4,
    R_RSP   = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_skid_reg.sv
// One-entry channel buffer: accepts a beat when empty, holds it until the owner frees it.
module axil_skid_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             free
);

  logic             full_reg;
  logic [WIDTH-1:0] data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_reg <= 1'b0;
      data_reg <= '0;
    end else if (free) begin
      full_reg <= 1'b0;
    end else if (in_valid && !full_reg) begin
      full_reg <= 1'b1;
      data_reg <= in_data;
    end
  end

  // Ready is forced low for the whole time reset is held.
  assign in_ready  = rst_n && !full_reg;
  assign out_valid = full_reg;
  assign out_data  = data_reg;

endmodule

// File: rtl/axil_mem_bridge.sv
// AXI-lite slave to simple memory request bridge with one memory operation in flight.
// Define AXIL_BRIDGE_RANGE_CHK_EN to answer SLVERR for addresses beyond the memory span.
module axil_mem_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int MEM_ADDR_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_WIDTH-1:0]     s_axil_awaddr,
  input  logic [2:0]                s_axil_awprot,
  input  logic                      s_axil_awvalid,
  output logic                      s_axil_awready,
  input  logic [DATA_WIDTH-1:0]     s_axil_wdata,
  input  logic [STRB_WIDTH-1:0]     s_axil_wstrb,
  input  logic                      s_axil_wvalid,
  output logic                      s_axil_wready,
  output logic [1:0]                s_axil_bresp,
  output logic                      s_axil_bvalid,
  input  logic                      s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]     s_axil_araddr,
  input  logic [2:0]                s_axil_arprot,
  input  logic                      s_axil_arvalid,
  output logic                      s_axil_arready,
  output logic [DATA_WIDTH-1:0]     s_axil_rdata,
  output logic [1:0]                s_axil_rresp,
  output logic                      s_axil_rvalid,
  input  logic                      s_axil_rready,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [STRB_WIDTH-1:0]     mem_wstrb,
  input  logic                      mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);
  import axil_pkg::*;

  localparam int LSB = $clog2(STRB_WIDTH);

  logic                             aw_full, w_full, ar_full;
  logic                             aw_free, w_free, ar_free;
  logic [ADDR_WIDTH-1:0]            aw_addr, ar_addr;
  logic [DATA_WIDTH+STRB_WIDTH-1:0] w_buf;
  logic                             wr_oor, rd_oor, wr_ready, rd_ready;
  logic                             unused_bits;

  state_t                state_reg, state_next;
  logic                  last_wr_reg, last_wr_next;
  logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
  logic [1:0]            bresp_reg, bresp_next;
  logic [1:0]            rresp_reg, rresp_next;

  axil_skid_reg #(.WIDTH(ADDR_WIDTH)) u_aw_buf (
    .clk(clk), .rst_n(rst_n), .in_valid(s_axil_awvalid), .in_ready(s_axil_awready),
    .in_data(s_axil_awaddr), .out_valid(aw_full), .out_data(aw_addr), .free(aw_free)
  );

  axil_skid_reg #(.WIDTH(DATA_WIDTH + STRB_WIDTH)) u_w_buf (
    .clk(clk), .rst_n(rst_n), .in_valid(s_axil_wvalid), .in_ready(s_axil_wready),
    .in_data({s_axil_wstrb, s_axil_wdata}), .out_valid(w_full), .out_data(w_buf), .free(w_free)
  );

  axil_skid_reg #(.WIDTH(ADDR_WIDTH)) u_ar_buf (
    .clk(clk), .rst_n(rst_n), .in_valid(s_axil_arvalid), .in_ready(s_axil_arready),
    .in_data(s_axil_araddr), .out_valid(ar_full), .out_data(ar_addr), .free(ar_free)
  );

`ifdef AXIL_BRIDGE_RANGE_CHK_EN
  assign wr_oor = |aw_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH];
  assign rd_oor = |ar_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH];
`else
  assign wr_oor = 1'b0;
  assign rd_oor = 1'b0;
`endif

  // Protection bits and the address bits outside the word index carry no meaning here.
  assign unused_bits = ^{s_axil_awprot, s_axil_arprot, aw_addr, ar_addr};

  assign wr_ready = aw_full && w_full;
  assign rd_ready = ar_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      last_wr_reg <= 1'b0;
      rdata_reg   <= '0;
      bresp_reg   <= RESP_OKAY;
      rresp_reg   <= RESP_OKAY;
    end else begin
      state_reg   <= state_next;
      last_wr_reg <= last_wr_next;
      rdata_reg   <= rdata_next;
      bresp_reg   <= bresp_next;
      rresp_reg   <= rresp_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    last_wr_next = last_wr_reg;
    rdata_next   = rdata_reg;
    bresp_next   = bresp_reg;
    rresp_next   = rresp_reg;
    aw_free      = 1'b0;
    w_free       = 1'b0;
    ar_free      = 1'b0;
    case (state_reg)
      IDLE: begin
        // Priority only flips when both directions actually compete.
        if (wr_ready && rd_ready) begin
          last_wr_next = !last_wr_reg;
        end
        if (wr_ready && (!rd_ready || !last_wr_reg)) begin
          if (wr_oor) begin
            aw_free    = 1'b1;
            w_free     = 1'b1;
            bresp_next = RESP_SLVERR;
            state_next = B_RSP;
          end else begin
            bresp_next = RESP_OKAY;
            state_next = WR_REQ;
          end
        end else if (rd_ready) begin
          if (rd_oor) begin
            ar_free    = 1'b1;
            rdata_next = '0;
            rresp_next = RESP_SLVERR;
            state_next = R_RSP;
          end else begin
            rresp_next = RESP_OKAY;
            state_next = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        if (mem_req_ready) begin
          aw_free    = 1'b1;
          w_free     = 1'b1;
          state_next = B_RSP;
        end
      end
      B_RSP: begin
        if (s_axil_bready) state_next = IDLE;
      end
      RD_REQ: begin
        if (mem_req_ready) begin
          ar_free = 1'b1;
          // The memory may answer in the very cycle it accepts the request.
          if (mem_rsp_valid) begin
            rdata_next = mem_rdata;
            state_next = R_RSP;
          end else begin
            state_next = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (mem_rsp_valid) begin
          rdata_next = mem_rdata;
          state_next = R_RSP;
        end
      end
      R_RSP: begin
        if (s_axil_rready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_req_valid = (state_reg == WR_REQ) || (state_reg == RD_REQ);
  assign mem_we        = (state_reg == WR_REQ);
  assign mem_addr      = mem_we ? {aw_addr[MEM_ADDR_WIDTH-1:LSB], {LSB{1'b0}}}
                                : {ar_addr[MEM_ADDR_WIDTH-1:LSB], {LSB{1'b0}}};
  assign mem_wdata     = w_buf[DATA_WIDTH-1:0];
  assign mem_wstrb     = w_buf[DATA_WIDTH +: STRB_WIDTH];

  assign s_axil_bvalid = (state_reg == B_RSP);
  assign s_axil_bresp  = bresp_reg;
  assign s_axil_rvalid = (state_reg == R_RSP);
  assign s_axil_rresp  = rresp_reg;
  assign s_axil_rdata  = rdata_reg;

endmodule

// File: tb/tb_axil_mem_bridge.sv
// Scoreboard bench for axil_mem_bridge: directed scenarios plus randomized sequential traffic.
module tb_axil_mem_bridge;
  import axil_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] s_axil_awaddr, s_axil_araddr, s_axil_wdata, s_axil_rdata;
  logic [2:0]  s_axil_awprot, s_axil_arprot;
  logic        s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
  logic [3:0]  s_axil_wstrb;
  logic [1:0]  s_axil_bresp, s_axil_rresp;
  logic        s_axil_bvalid, s_axil_bready, s_axil_arvalid, s_axil_arready;
  logic        s_axil_rvalid, s_axil_rready;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  axil_mem_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } mreq_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rrsp_t;

  mreq_t       exp_mem[$];
  logic [1:0]  exp_b[$];
  rrsp_t       exp_r[$];
  logic [31:0] ref_mem[int];
  logic [31:0] dev_mem[int];
  int          checks = 0;
  int          errors = 0;
  int          rsp_delay = 0;
  bit          rand_rdy = 1'b0;
  bit          hold_r = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    return w;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(int'(a[15:2])) ? ref_mem[int'(a[15:2])] : 32'h0;
  endfunction

  function automatic logic [31:0] dev_rd(input logic [15:0] a);
    return dev_mem.exists(int'(a[15:2])) ? dev_mem[int'(a[15:2])] : 32'h0;
  endfunction

  // Expected effects of one write, in the order the bridge must serve it.
  task automatic exp_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    mreq_t m;
    m.we = 1'b1; m.addr = {a[15:2], 2'b00}; m.data = d; m.strb = s;
    exp_mem.push_back(m);
    ref_mem[int'(a[15:2])] = merge(ref_rd(a), d, s);
    exp_b.push_back(RESP_OKAY);
  endtask

  task automatic exp_read(input logic [15:0] a, input bit with_rsp);
    mreq_t m;
    rrsp_t r;
    m.we = 1'b0; m.addr = {a[15:2], 2'b00}; m.data = 32'h0; m.strb = 4'h0;
    exp_mem.push_back(m);
    r.data = ref_rd(a); r.resp = RESP_OKAY;
    if (with_rsp) exp_r.push_back(r);
  endtask

  task automatic send_aw(input logic [31:0] a, input int dly);
    int n; bit hs;
    n = 0; hs = 1'b0;
    if (dly > 0) begin repeat (dly) @(posedge clk); #1; end
    s_axil_awaddr = a; s_axil_awprot = 3'($urandom_range(0, 7)); s_axil_awvalid = 1'b1;
    while (!hs && n < 200) begin @(negedge clk); hs = s_axil_awready; @(posedge clk); #1; n++; end
    s_axil_awvalid = 1'b0;
    if (!hs) chk("aw_handshake_timeout", 64'(hs), 64'h1);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    int n; bit hs;
    n = 0; hs = 1'b0;
    if (dly > 0) begin repeat (dly) @(posedge clk); #1; end
    s_axil_wdata = d; s_axil_wstrb = s; s_axil_wvalid = 1'b1;
    while (!hs && n < 200) begin @(negedge clk); hs = s_axil_wready; @(posedge clk); #1; n++; end
    s_axil_wvalid = 1'b0;
    if (!hs) chk("w_handshake_timeout", 64'(hs), 64'h1);
  endtask

  task automatic send_ar(input logic [31:0] a);
    int n; bit hs;
    n = 0; hs = 1'b0;
    s_axil_araddr = a; s_axil_arprot = 3'($urandom_range(0, 7)); s_axil_arvalid = 1'b1;
    while (!hs && n < 200) begin @(negedge clk); hs = s_axil_arready; @(posedge clk); #1; n++; end
    s_axil_arvalid = 1'b0;
    if (!hs) chk("ar_handshake_timeout", 64'(hs), 64'h1);
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int da, input int dw);
    fork
      send_aw(a, da);
      send_w(d, s, dw);
    join
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((exp_mem.size() + exp_b.size() + exp_r.size()) != 0 && n < 500) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_drain_pending"}, 64'(exp_mem.size() + exp_b.size() + exp_r.size()), 64'h0);
    exp_mem.delete(); exp_b.delete(); exp_r.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Memory device: random or fixed accept, read data returned after rsp_delay cycles.
  initial begin : responder
    int          pend;
    int          d;
    logic [31:0] pend_data;
    pend = 0; d = 0; pend_data = 32'h0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      if (!rst_n) begin
        pend = 0;
        mem_req_ready = 1'b0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin mem_rsp_valid = 1'b1; mem_rdata = pend_data; end
        end
        mem_req_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        if (mem_req_valid && mem_req_ready) begin
          if (mem_we) begin
            dev_mem[int'(mem_addr[15:2])] = merge(dev_rd(mem_addr), mem_wdata, mem_wstrb);
          end else begin
            d = (rsp_delay < 0) ? int'($urandom_range(0, 3)) : rsp_delay;
            if (d == 0) begin
              mem_rsp_valid = 1'b1;
              mem_rdata = dev_rd(mem_addr);
            end else begin
              pend = d;
              pend_data = dev_rd(mem_addr);
            end
          end
        end
      end
    end
  end

  initial begin : resp_ready_driver
    s_axil_bready = 1'b0; s_axil_rready = 1'b0;
    forever begin
      @(posedge clk); #1;
      s_axil_bready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      s_axil_rready = hold_r ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  initial begin : monitor
    mreq_t      em;
    rrsp_t      er;
    logic [1:0] eb;
    forever begin
      @(negedge clk); #1;
      if (rst_n) begin
        if (mem_req_valid && mem_req_ready) begin
          if (exp_mem.size() == 0) begin
            chk("mem_req_unexpected", 64'({mem_we, mem_addr}), 64'h0);
            if (mem_we == 1'b0 && mem_addr == 16'h0) chk("mem_req_unexpected_rd0", 64'h1, 64'h0);
          end else begin
            em = exp_mem.pop_front();
            chk("mem_we", 64'(mem_we), 64'(em.we));
            chk("mem_addr", 64'(mem_addr), 64'(em.addr));
            if (em.we) begin
              chk("mem_wdata", 64'(mem_wdata), 64'(em.data));
              chk("mem_wstrb", 64'(mem_wstrb), 64'(em.strb));
            end
          end
        end
        if (s_axil_bvalid && s_axil_bready) begin
          if (exp_b.size() == 0) begin
            chk("b_unexpected", 64'h1, 64'h0);
          end else begin
            eb = exp_b.pop_front();
            chk("bresp", 64'(s_axil_bresp), 64'(eb));
          end
        end
        if (s_axil_rvalid && s_axil_rready) begin
          if (exp_r.size() == 0) begin
            chk("r_unexpected", 64'h1, 64'h0);
          end else begin
            er = exp_r.pop_front();
            chk("rdata", 64'(s_axil_rdata), 64'(er.data));
            chk("rresp", 64'(s_axil_rresp), 64'(er.resp));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation did not complete");
  end

  initial begin : stim
    int          n;
    logic [31:0] a, d;
    logic [3:0]  s;
    rrsp_t       r;
    s_axil_awaddr = 32'h0; s_axil_awprot = 3'h0; s_axil_awvalid = 1'b0;
    s_axil_wdata = 32'h0; s_axil_wstrb = 4'h0; s_axil_wvalid = 1'b0;
    s_axil_araddr = 32'h0; s_axil_arprot = 3'h0; s_axil_arvalid = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_readies", 64'({s_axil_awready, s_axil_wready, s_axil_arready}), 64'h0);
    chk("rst_valids", 64'({s_axil_bvalid, s_axil_rvalid, mem_req_valid}), 64'h0);
    chk("rst_resp_data", 64'({s_axil_bresp, s_axil_rresp, s_axil_rdata}), 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_readies", 64'({s_axil_awready, s_axil_wready, s_axil_arready}), 64'h7);

    // Single write with AW and W together.
    exp_write(16'h0010, 32'hDEADBEEF, 4'hF);
    send_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
    wait_idle("single_write");

    // W leads AW by three cycles; nothing may reach memory meanwhile.
    exp_write(16'h0020, 32'hA5A5_1234, 4'h3);
    send_w(32'hA5A5_1234, 4'h3, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("w_first_no_req", 64'(mem_req_valid), 64'h0);
      @(posedge clk); #1;
    end
    send_aw(32'h20, 0);
    wait_idle("w_before_aw");

    // Late read response with the master stalling rready.
    ref_mem[int'(16'h0024 >> 2)] = 32'h1234_5678;
    dev_mem[int'(16'h0024 >> 2)] = 32'h1234_5678;
    rsp_delay = 2;
    hold_r = 1'b1;
    @(posedge clk); #1;
    exp_read(16'h0024, 1'b1);
    send_ar(32'h24);
    n = 0;
    while (!s_axil_rvalid && n < 50) begin @(negedge clk); n++; end
    chk("late_read_rvalid_seen", 64'(s_axil_rvalid), 64'h1);
    for (int i = 0; i < 4; i++) begin
      chk("rvalid_held", 64'(s_axil_rvalid), 64'h1);
      chk("rdata_held", 64'(s_axil_rdata), 64'h1234_5678);
      @(negedge clk);
    end
    hold_r = 1'b0;
    wait_idle("late_read");

    // Two contended rounds: write wins first, read wins second.
    rsp_delay = 0;
    exp_write(16'h0040, 32'h1111_2222, 4'hF);
    exp_read(16'h0080, 1'b1);
    fork
      send_write(32'h40, 32'h1111_2222, 4'hF, 0, 0);
      send_ar(32'h80);
    join
    wait_idle("contend_1");
    exp_read(16'h0044, 1'b1);
    exp_write(16'h0044, 32'h3333_4444, 4'hF);
    fork
      send_write(32'h44, 32'h3333_4444, 4'hF, 0, 0);
      send_ar(32'h44);
    join
    wait_idle("contend_2");

    // Randomized sequential traffic against the reference memory.
    rand_rdy = 1'b1;
    rsp_delay = -1;
    for (int t = 0; t < 40; t++) begin
      a = 32'($urandom_range(0, 31)) << 2;
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(1, 15));
        exp_write(a[15:0], d, s);
        send_write(a, d, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end else begin
        exp_read(a[15:0], 1'b1);
        send_ar(a);
      end
      wait_idle("random");
    end
    rand_rdy = 1'b0;

    // Reset while the read waits on memory: no response may follow.
    rsp_delay = 6;
    exp_read(16'h0030, 1'b0);
    send_ar(32'h30);
    n = 0;
    while (!(mem_req_valid && mem_req_ready) && n < 50) begin @(negedge clk); #1; n++; end
    chk("rst_test_req_seen", 64'(mem_req_valid && mem_req_ready), 64'h1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("midrst_readies", 64'({s_axil_awready, s_axil_wready, s_axil_arready}), 64'h0);
      chk("midrst_valids", 64'({s_axil_bvalid, s_axil_rvalid, mem_req_valid}), 64'h0);
      chk("midrst_resp_data", 64'({s_axil_bresp, s_axil_rresp, s_axil_rdata}), 64'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_no_rvalid", 64'(s_axil_rvalid), 64'h0);
    end
    exp_mem.delete();
    @(posedge clk); #1;
    rsp_delay = 1;
    exp_read(16'h0030, 1'b1);
    send_ar(32'h30);
    wait_idle("read_after_reset");

`ifdef AXIL_BRIDGE_RANGE_CHK_EN
    exp_b.push_back(RESP_SLVERR);
    send_write(32'h0001_0000, 32'hCAFE_F00D, 4'hF, 0, 0);
    wait_idle("oor_write");
    r.data = 32'h0; r.resp = RESP_SLVERR;
    exp_r.push_back(r);
    send_ar(32'h0002_0004);
    wait_idle("oor_read");
`else
    exp_write(16'h0040, 32'hCAFE_F00D, 4'hF);
    send_write(32'h0001_0040, 32'hCAFE_F00D, 4'hF, 0, 0);
    wait_idle("trunc_write");
    exp_read(16'h0040, 1'b1);
    send_ar(32'h0001_0040);
    wait_idle("trunc_read");
    r.data = 32'h0; r.resp = RESP_OKAY;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
